// File: rtl/bcd_gray_stream.sv
`default_nettype none
// ============================================================================
// Module   : bcd_gray_stream
// Brief    : Valid/ready word converter, BCD<->Gray, one digit per enabled cycle
// Revision : 1.0
// ============================================================================
module bcd_gray_stream #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic [DIGITS-1:0]     out_err,
  output logic                  busy
);

  localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [4*DIGITS-1:0]  r_src;
  logic                 r_mode;
  logic [c_IDX_W-1:0]   r_idx;
  logic [3:0]           w_src_digit;
  logic [4:0]           w_conv;
  logic                 w_accept;
  logic                 w_step;
  logic                 w_last;

  // Result packing for both tables: {err, digit}
  function automatic logic [4:0] f_bcd2gray(input logic [3:0] d);
    case (d)
      4'h0:    f_bcd2gray = {1'b0, 4'h0};
      4'h1:    f_bcd2gray = {1'b0, 4'h1};
      4'h2:    f_bcd2gray = {1'b0, 4'h3};
      4'h3:    f_bcd2gray = {1'b0, 4'h2};
      4'h4:    f_bcd2gray = {1'b0, 4'h6};
      4'h5:    f_bcd2gray = {1'b0, 4'h7};
      4'h6:    f_bcd2gray = {1'b0, 4'h5};
      4'h7:    f_bcd2gray = {1'b0, 4'h4};
      4'h8:    f_bcd2gray = {1'b0, 4'hC};
      4'h9:    f_bcd2gray = {1'b0, 4'hD};
      default: f_bcd2gray = {1'b1, 4'h0};
    endcase
  endfunction

  function automatic logic [4:0] f_gray2bcd(input logic [3:0] g);
    case (g)
      4'h0:    f_gray2bcd = {1'b0, 4'h0};
      4'h1:    f_gray2bcd = {1'b0, 4'h1};
      4'h3:    f_gray2bcd = {1'b0, 4'h2};
      4'h2:    f_gray2bcd = {1'b0, 4'h3};
      4'h6:    f_gray2bcd = {1'b0, 4'h4};
      4'h7:    f_gray2bcd = {1'b0, 4'h5};
      4'h5:    f_gray2bcd = {1'b0, 4'h6};
      4'h4:    f_gray2bcd = {1'b0, 4'h7};
      4'hC:    f_gray2bcd = {1'b0, 4'h8};
      4'hD:    f_gray2bcd = {1'b0, 4'h9};
      default: f_gray2bcd = {1'b1, 4'h0};
    endcase
  endfunction

  always_comb begin
    w_src_digit = r_src[4*int'(r_idx) +: 4];
    w_conv      = r_mode ? f_gray2bcd(w_src_digit) : f_bcd2gray(w_src_digit);
    w_accept    = in_valid && (r_state == S_IDLE);
    w_step      = en && (r_state == S_CONV);
    w_last      = w_step && (r_idx == c_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_nxt = S_CONV;
      end
      S_CONV: begin
        if (w_last) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Source word and mode are captured at accept so later input changes are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src    <= '0;
      r_mode   <= 1'b0;
      r_idx    <= '0;
      out_data <= '0;
      out_err  <= '0;
    end else if (w_accept) begin
      r_src    <= in_data;
      r_mode   <= mode;
      r_idx    <= '0;
      out_data <= '0;
      out_err  <= '0;
    end else if (w_step) begin
      out_data[4*int'(r_idx) +: 4] <= w_conv[3:0];
      out_err[r_idx]               <= w_conv[4];
      if (w_last) begin
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_gray_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_gray_stream
// Brief    : Self-checking bench for bcd_gray_stream against an arithmetic model
// Revision : 1.0
// ============================================================================
module tb_bcd_gray_stream;

  localparam int D = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b1;
  logic           mode = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [4*D-1:0] in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [4*D-1:0] out_data;
  logic [D-1:0]   out_err;
  logic           busy;

  int checks = 0;
  int errors = 0;

  bcd_gray_stream #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Gray code is d ^ (d>>1); decoding is the prefix XOR of the code bits
  function automatic void ref_word(input logic [4*D-1:0] d, input logic m,
                                   output logic [4*D-1:0] od, output logic [D-1:0] oe);
    int v, r;
    od = '0;
    oe = '0;
    for (int i = 0; i < D; i++) begin
      v = int'(d[4*i +: 4]);
      if (!m) r = v ^ (v >> 1);
      else    r = v ^ (v >> 1) ^ (v >> 2) ^ (v >> 3);
      if ((m ? r : v) > 9) oe[i] = 1'b1;
      else                 od[4*i +: 4] = 4'(m ? r : r);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4*D-1:0] d, input logic m);
    in_data  = d;
    mode     = m;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    mode     = 1'($urandom);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; en = 1'b1;
    tick(); tick();
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_flags: got v/b/r=%b expected 001", {out_valid, busy, in_ready});
    end
    checks++;
    if (out_data !== 16'h0 || out_err !== 4'h0) begin
      errors++;
      $display("FAIL reset_data: got %h/%b expected 0000/0000", out_data, out_err);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [4*D-1:0] vin  [4] = '{16'h9876, 16'h12A4, 16'hDC45, 16'h8F00};
    logic           vm   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [4*D-1:0] vout [4] = '{16'hDC45, 16'h1306, 16'h9876, 16'h0000};
    logic [D-1:0]   verr [4] = '{4'b0000, 4'b0010, 4'b0000, 4'b1100};
    int n;
    for (int k = 0; k < 4; k++) begin
      send(vin[k], vm[k]);
      wait_valid(n);
      checks++;
      if (n !== D) begin
        errors++;
        $display("FAIL dir_latency[%0d]: got %0d edges expected %0d", k, n, D);
      end
      checks++;
      if (out_data !== vout[k] || out_err !== verr[k]) begin
        errors++;
        $display("FAIL dir_result[%0d]: got %h/%b expected %h/%b", k, out_data, out_err, vout[k], verr[k]);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir_release[%0d]: got v=%b r=%b expected v=0 r=1", k, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [4*D-1:0] ed;
    logic [D-1:0]   ee;
    int n;
    ref_word(16'h3579, 1'b0, ed, ee);
    out_ready = 1'b0;
    send(16'h3579, 1'b0);
    wait_valid(n);
    in_valid = 1'b1;
    in_data  = 16'h1111;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== ed || out_err !== ee) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b r=%b %h/%b expected v=1 r=0 %h/%b",
                 c, out_valid, in_ready, out_data, out_err, ed, ee);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got r=%b v=%b b=%b expected r=1 v=0 b=0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_en_stall();
    logic [4*D-1:0] ed;
    logic [D-1:0]   ee;
    int n;
    ref_word(16'h0519, 1'b0, ed, ee);
    send(16'h0519, 1'b0);
    tick();
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mode = ~mode;
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || out_data[3:0] !== ed[3:0] || out_err[0] !== ee[0]) begin
      errors++;
      $display("FAIL stall_partial: got v=%b d0=%h expected v=0 d0=%h", out_valid, out_data[3:0], ed[3:0]);
    end
    en = 1'b1;
    wait_valid(n);
    checks++;
    if (n !== D - 1) begin
      errors++;
      $display("FAIL stall_latency: got %0d edges expected %0d", n, D - 1);
    end
    checks++;
    if (out_data !== ed || out_err !== ee) begin
      errors++;
      $display("FAIL stall_result: got %h/%b expected %h/%b", out_data, out_err, ed, ee);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [4*D-1:0] ed;
    logic [D-1:0]   ee;
    int n;
    send(16'h9999, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 || out_err !== '0) begin
      errors++;
      $display("FAIL rst_conv: got r=%b v=%b b=%b %h/%b expected r=1 v=0 b=0 0000/0000",
               in_ready, out_valid, busy, out_data, out_err);
    end
    out_ready = 1'b0;
    send(16'h4AB2, 1'b1);
    wait_valid(n);
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL rst_hold: got r=%b v=%b d=%h expected r=1 v=0 d=0000", in_ready, out_valid, out_data);
    end
    ref_word(16'h0642, 1'b0, ed, ee);
    send(16'h0642, 1'b0);
    wait_valid(n);
    checks++;
    if (n !== D || out_data !== ed || out_err !== ee) begin
      errors++;
      $display("FAIL rst_after: got n=%0d %h/%b expected n=%0d %h/%b", n, out_data, out_err, D, ed, ee);
    end
    tick();
  endtask

  task automatic test_random();
    logic [4*D-1:0] d, ed, hd;
    logic [D-1:0]   ee;
    logic           m, early, took, unstable;
    int cnt, guard;
    for (int k = 0; k < 30; k++) begin
      d = 16'($urandom);
      if (k % 3 == 0) begin
        for (int i = 0; i < D; i++) d[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      m = 1'($urandom);
      ref_word(d, m, ed, ee);
      send(d, m);
      cnt = 0; early = 1'b0; guard = 0;
      while (cnt < D && guard < 200) begin
        en      = ($urandom_range(0, 3) != 0);
        mode    = 1'($urandom);
        in_data = 16'($urandom);
        if (out_valid !== 1'b0) early = 1'b1;
        tick();
        if (en) cnt++;
        guard++;
      end
      en = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || early) begin
        errors++;
        $display("FAIL rnd_timing[%0d]: got v=%b early=%b expected v=1 early=0", k, out_valid, early);
      end
      checks++;
      if (out_data !== ed || out_err !== ee) begin
        errors++;
        $display("FAIL rnd_result[%0d] in=%h m=%b: got %h/%b expected %h/%b", k, d, m, out_data, out_err, ed, ee);
      end
      hd = out_data; unstable = 1'b0; guard = 0;
      do begin
        out_ready = ($urandom_range(0, 2) == 0);
        took = out_ready;
        if (out_valid !== 1'b1 || out_data !== hd) unstable = 1'b1;
        tick();
        guard++;
      end while (!took && guard < 50);
      out_ready = 1'b1;
      checks++;
      if (unstable || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rnd_hold[%0d]: got unstable=%b r=%b expected unstable=0 r=1", k, unstable, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_en_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_gray_stream.md
BCD_GRAY_STREAM -- requirements
Module: bcd_gray_stream

Interface
- REQ-001: Parameter DIGITS, default 4, SHALL set the number of 4-bit digits per word; legal range 1..16.
- REQ-002: clk  input  1  SHALL be the single clock; all state changes on its rising edge.
- REQ-003: rst  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk.
- REQ-004: en  input  1  SHALL be the conversion enable; when 0, conversion progress freezes.
- REQ-005: mode  input  1  SHALL select the direction: 0 = BCD->Gray, 1 = Gray->BCD; sampled only at accept.
- REQ-006: in_valid  input  1  SHALL indicate that in_data holds a word.
- REQ-007: in_ready  output  1  SHALL indicate that the block can accept a word.
- REQ-008: in_data  input  4*DIGITS  SHALL carry the packed digits; digit i occupies bits [4i+3:4i], digit 0 is least significant.
- REQ-009: out_valid  output  1  SHALL indicate that out_data and out_err hold a completed result.
- REQ-010: out_ready  input  1  SHALL indicate that the consumer takes the result.
- REQ-011: out_data  output  4*DIGITS  SHALL carry the converted digits, using the same packing as in_data.
- REQ-012: out_err  output  DIGITS  SHALL flag, per digit, that the source digit was invalid.
- REQ-013: busy  output  1  SHALL be 1 in any state other than IDLE.

Function
- REQ-014: The FSM SHALL have exactly three states: IDLE, CONV and HOLD.
- REQ-015: in_ready SHALL be 1 only in IDLE, independent of en.
- REQ-016: Accept SHALL occur when in_valid and in_ready are both 1 at a rising edge; on accept the block latches in_data and mode, clears the digit index to 0, clears out_err, and moves to CONV.
- REQ-017: In CONV, on each edge with en=1, the block SHALL convert digit[index], write the result into out_data digit[index] and out_err[index], and increment the index.
- REQ-018: In CONV, when the index equals DIGITS-1 and en=1, the block SHALL write the last digit and move to HOLD.
- REQ-019: In CONV with en=0, the index, out_data and out_err SHALL hold.
- REQ-020: Latency SHALL be DIGITS enabled cycles: with en held at 1, out_valid rises DIGITS edges after the accept edge.
- REQ-021: In HOLD, out_valid SHALL be 1 and out_data and out_err SHALL be stable; on an edge with out_ready=1 the block returns to IDLE.
- REQ-022: out_valid SHALL be 0 in IDLE and in CONV; a new word is accepted no earlier than the edge after the HOLD->IDLE edge.
- REQ-023: BCD->Gray mapping SHALL be: 0->0, 1->1, 2->3, 3->2, 4->6, 5->7, 6->5, 7->4, 8->C, 9->D.
- REQ-024: In BCD->Gray mode, source digits A..F SHALL produce output digit 0 and err=1.
- REQ-025: Gray->BCD mapping SHALL be the exact inverse of REQ-023.
- REQ-026: In Gray->BCD mode, codes outside {0,1,3,2,6,7,5,4,C,D} SHALL produce output digit 0 and err=1.
- REQ-027: Changes on mode or in_data after the accept edge SHALL NOT affect the word in flight.
- REQ-028: With DIGITS=1, CONV SHALL last one enabled cycle; the index logic SHALL be at least 1 bit wide.

Reset
- REQ-029: With rst=1 at an edge, the block SHALL enter IDLE from any state, including mid-CONV and HOLD, and discard the word in flight.
- REQ-030: Reset values SHALL be: out_valid=0, busy=0, out_data=0, out_err=0, index=0, in_ready=1 from the first cycle after reset.
- REQ-031: rst SHALL override en, in_valid and out_ready.

Verification
- REQ-032: DIGITS=4, mode=0, in_data=16'h9876, en=1, out_ready=1 -> out_valid after 4 edges; out_data=16'hDC45, out_err=4'b0000.
- REQ-033: mode=0, in_data=16'h12A4 -> out_data=16'h1306, out_err=4'b0010.
- REQ-034: mode=1, in_data=16'hDC45 -> out_data=16'h9876, out_err=0; mode=1, in_data=16'h8F00 -> out_data=16'h0000, out_err=4'b1100.
- REQ-035: Hold out_ready=0 for 5 cycles in HOLD -> out_valid stays 1 with data stable and in_ready=0; raise out_ready -> IDLE the next edge, in_ready=1.
- REQ-036: Drop en for 3 cycles during CONV -> out_valid arrives 3 edges late with the correct data; toggle mode mid-CONV -> result unchanged.
- REQ-037: Assert rst at the second CONV edge -> next cycle IDLE with out_valid=0, out_data=0 and in_ready=1; a following word converts correctly.
